// File: rtl/ftdi_pkg.sv
// Shared types and default sizing for the FTDI TX arbiter slice.
package ftdi_pkg;

   localparam int unsigned FTDI_DW        = 8;
   localparam int unsigned FTDI_UW        = 11;
   localparam int unsigned FTDI_BURST_MAX = 64;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/ftdi_tx_skid.sv
// Two-entry output buffer; the head register drives the FTDI data bus directly.
module ftdi_tx_skid
   import ftdi_pkg::*;
#(
   parameter int unsigned DW = FTDI_DW
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [DW-1:0] i_din,
   output logic [1:0]    o_occ,
   output logic [DW-1:0] o_head
);

   logic [DW-1:0] r_head;
   logic [DW-1:0] r_tail;
   logic [1:0]    r_occ;

   // Entries shift tail->head on pop so the head is always a plain register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_head <= i_din;
               else               r_tail <= i_din;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_head <= r_tail;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_head <= i_din;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_din;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_occ  = r_occ;
   assign o_head = r_head;

   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_push && !i_pop && (r_occ == 2'd2)));
   a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_pop && (r_occ == 2'd0)));

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Round-robin, burst-limited scheduler sharing the FTDI TX path between two source FIFOs.
module ftdi_tx_arbiter
   import ftdi_pkg::*;
#(
   parameter int unsigned DW        = FTDI_DW,
   parameter int unsigned UW        = FTDI_UW,
   parameter int unsigned BURST_MAX = FTDI_BURST_MAX
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [UW-1:0] s0_usedw,
   input  logic          s0_wrreq,
   output logic          s0_rdreq,
   input  logic [DW-1:0] s0_q,
   input  logic [UW-1:0] s1_usedw,
   input  logic          s1_wrreq,
   output logic          s1_rdreq,
   input  logic [DW-1:0] s1_q,
   input  logic          ftdi_rx_rdy,
   output logic          ftdi_wr,
   output logic [DW-1:0] ftdi_data,
   output logic          grant_id,
   output logic          busy
);

   localparam logic [UW-1:0] BURST_LIM = UW'(BURST_MAX);

   state_t        r_state;
   logic [UW-1:0] r_cnt;
   logic          r_pend;
   logic          r_last;
   logic          r_grant;
   logic          r_elig0;
   logic          r_elig1;

   logic [1:0]    w_occ;
   logic [2:0]    w_room;
   logic          w_wr;
   logic          w_rdreq;
   logic          w_next_grant;
   logic [UW-1:0] w_usedw_g;
   logic [UW-1:0] w_burst;

   always_comb begin
      w_wr         = (w_occ != 2'd0) && ftdi_rx_rdy;
      // Occupancy after this cycle's pop plus the word already in flight.
      w_room       = {1'b0, w_occ} + {2'b00, r_pend} - {2'b00, w_wr};
      w_rdreq      = (r_state == BURST) && (r_cnt != '0) && ftdi_rx_rdy && (w_room <= 3'd1);
      w_next_grant = (r_elig0 && r_elig1) ? ~r_last : r_elig1;
      w_usedw_g    = w_next_grant ? s1_usedw : s0_usedw;
      w_burst      = (w_usedw_g > BURST_LIM) ? BURST_LIM : w_usedw_g;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pend  <= 1'b0;
         r_last  <= 1'b1;
         r_grant <= 1'b0;
         r_elig0 <= 1'b0;
         r_elig1 <= 1'b0;
      end else begin
         // usedw lags wrreq by a cycle, so eligibility is sampled one cycle late.
         r_elig0 <= (s0_usedw != '0) && !s0_wrreq;
         r_elig1 <= (s1_usedw != '0) && !s1_wrreq;
         r_pend  <= w_rdreq;
         case (r_state)
            IDLE: begin
               if (r_elig0 || r_elig1) begin
                  r_grant <= w_next_grant;
                  r_cnt   <= w_burst;
                  r_state <= BURST;
               end
            end
            BURST: begin
               if (w_rdreq) r_cnt <= r_cnt - 1'b1;
               if ((r_cnt == '0) && !r_pend) begin
                  r_last  <= r_grant;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   ftdi_tx_skid #(.DW(DW)) u_skid (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_push (r_pend),
      .i_pop  (w_wr),
      .i_din  (r_grant ? s1_q : s0_q),
      .o_occ  (w_occ),
      .o_head (ftdi_data)
   );

   assign s0_rdreq = w_rdreq && !r_grant;
   assign s1_rdreq = w_rdreq && r_grant;
   assign ftdi_wr  = w_wr;
   assign grant_id = r_grant;
   assign busy     = (r_state != IDLE) || (w_occ != 2'd0);

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Directed bench for ftdi_tx_arbiter with source FIFO models and a byte-stream scoreboard.
module tb_ftdi_tx_arbiter;
   import ftdi_pkg::*;

   localparam int TUW = 11;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [TUW-1:0] s0_usedw = '0, s1_usedw = '0;
   logic           s0_wrreq = 1'b0, s1_wrreq = 1'b0;
   logic           s0_rdreq, s1_rdreq;
   logic [7:0]     s0_q = '0, s1_q = '0;
   logic           ftdi_rx_rdy = 1'b1;
   logic           ftdi_wr;
   logic [7:0]     ftdi_data;
   logic           grant_id, busy;

   ftdi_tx_arbiter #(.DW(8), .UW(TUW), .BURST_MAX(64)) dut (
      .clk(clk), .rst(rst),
      .s0_usedw(s0_usedw), .s0_wrreq(s0_wrreq), .s0_rdreq(s0_rdreq), .s0_q(s0_q),
      .s1_usedw(s1_usedw), .s1_wrreq(s1_wrreq), .s1_rdreq(s1_rdreq), .s1_q(s1_q),
      .ftdi_rx_rdy(ftdi_rx_rdy), .ftdi_wr(ftdi_wr), .ftdi_data(ftdi_data),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Source FIFO models (non-show-ahead) and observation state
   logic [7:0] f0[$], f1[$];
   logic [7:0] expq[$];
   logic [7:0] out_log[$];
   int         wr_cyc[$];
   int         run_src[$], run_len[$];
   int         nrd0 = 0, nrd1 = 0, cyc = 0;
   int         avail = 0, inflight = 0;
   bit         in_rst = 1'b1, run_brk = 1'b1;
   bit         rd0_s = 1'b0, rd1_s = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         f0.delete();
         f1.delete();
         s0_q <= '0;
         s1_q <= '0;
      end else begin
         if (rd0_s && f0.size() > 0) s0_q <= f0.pop_front();
         if (rd1_s && f1.size() > 0) s1_q <= f1.pop_front();
      end
      s0_usedw <= TUW'(f0.size());
      s1_usedw <= TUW'(f1.size());
   end

   // Per-cycle compare: a word requested in cycle t is deliverable from cycle t+2,
   // and must then go out on every cycle the FTDI side is ready.
   always @(negedge clk) begin
      int src;
      cyc++;
      if (in_rst) begin
         check("rst_outputs", {s0_rdreq, s1_rdreq, ftdi_wr, grant_id, busy, ftdi_data}, 0);
         avail    = 0;
         inflight = 0;
         expq.delete();
         run_brk  = 1'b1;
         rd0_s    = 1'b0;
         rd1_s    = 1'b0;
      end else begin
         check("one_rdreq", s0_rdreq && s1_rdreq, 0);
         if (!ftdi_rx_rdy) check("rdreq_when_not_rdy", s0_rdreq || s1_rdreq, 0);
         check("ftdi_wr", ftdi_wr, ftdi_rx_rdy && (avail > 0));
         if (avail > 0) check("busy_with_data", busy, 1);
         if (ftdi_wr) begin
            out_log.push_back(ftdi_data);
            wr_cyc.push_back(cyc);
            if (expq.size() == 0) check("data_underrun", 0, 1);
            else                  check("ftdi_data", ftdi_data, expq.pop_front());
         end
         if (s0_rdreq) begin
            nrd0++;
            check("rd0_nonempty", f0.size() > 0, 1);
            if (f0.size() > 0) expq.push_back(f0[0]);
         end
         if (s1_rdreq) begin
            nrd1++;
            check("rd1_nonempty", f1.size() > 0, 1);
            if (f1.size() > 0) expq.push_back(f1[0]);
         end
         if (s0_rdreq || s1_rdreq) begin
            src = s1_rdreq ? 1 : 0;
            if (run_brk || run_src.size() == 0 || run_src[run_src.size()-1] != src) begin
               run_src.push_back(src);
               run_len.push_back(1);
            end else begin
               run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
            end
            run_brk = 1'b0;
         end
         avail    = avail + inflight - (ftdi_wr ? 1 : 0);
         inflight = (s0_rdreq || s1_rdreq) ? 1 : 0;
         check("occ_max", avail <= 2, 1);
         rd0_s = s0_rdreq;
         rd1_s = s1_rdreq;
      end
      in_rst = rst;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit is_done();
      return (f0.size() == 0) && (f1.size() == 0) && (expq.size() == 0) && !busy;
   endfunction

   task automatic wait_done(input string nm, input int maxc);
      int c;
      for (c = 0; c < maxc && !is_done(); c++) step();
      check({nm, "_timeout"}, is_done(), 1);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      ftdi_rx_rdy = 1'b1;
      s0_wrreq = 1'b0;
      s1_wrreq = 1'b0;
   endtask

   int bo, br, b0, b1;
   int exp_src[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
   int exp_len[8] = '{64, 64, 64, 64, 64, 64, 8, 8};

   initial begin
      // Test 1: reset with random control inputs
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ftdi_rx_rdy = 1'($urandom_range(0, 1));
         s0_wrreq    = 1'($urandom_range(0, 1));
         s1_wrreq    = 1'($urandom_range(0, 1));
         step();
      end
      rst = 1'b0;
      ftdi_rx_rdy = 1'b1;
      s0_wrreq = 1'b0;
      s1_wrreq = 1'b0;
      step();

      // Test 2: five bytes from s0
      bo = out_log.size(); br = run_src.size(); b0 = nrd0; b1 = nrd1;
      for (int i = 0; i < 5; i++) f0.push_back(8'(i + 1));
      wait_done("t2", 200);
      step(); step();
      check("t2_rd0_count", nrd0 - b0, 5);
      check("t2_rd1_count", nrd1 - b1, 0);
      check("t2_bytes", out_log.size() - bo, 5);
      if (out_log.size() - bo == 5) begin
         for (int i = 0; i < 5; i++) begin
            check("t2_byte", out_log[bo+i], i + 1);
            check("t2_consecutive", wr_cyc[bo+i] - wr_cyc[bo], i);
         end
      end
      check("t2_idle_busy", busy, 0);
      check("t2_first_grant_s0", (run_src.size() > br) ? run_src[br] : -1, 0);

      // Test 3: both sources 200 deep, BURST_MAX 64
      reset_dut();
      bo = out_log.size(); br = run_src.size();
      for (int i = 0; i < 200; i++) begin
         f0.push_back(8'(i));
         f1.push_back(8'(255 - i));
      end
      wait_done("t3", 3000);
      check("t3_runs", run_src.size() - br, 8);
      if (run_src.size() - br == 8) begin
         for (int r = 0; r < 8; r++) begin
            check("t3_run_src", run_src[br+r], exp_src[r]);
            check("t3_run_len", run_len[br+r], exp_len[r]);
         end
      end
      check("t3_total", out_log.size() - bo, 400);
      if (out_log.size() - bo == 400) begin
         int p0, p1, idx;
         p0 = 0; p1 = 0; idx = 0;
         for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < exp_len[r]; k++) begin
               if (exp_src[r] == 0) begin check("t3_order", out_log[bo+idx], p0); p0++; end
               else begin check("t3_order", out_log[bo+idx], 255 - p1); p1++; end
               idx++;
            end
         end
      end

      // Test 4: 100-byte stream with ftdi_rx_rdy toggling
      bo = out_log.size(); b0 = nrd0;
      for (int i = 0; i < 100; i++) f0.push_back(8'(i * 3 + 7));
      for (int c = 0; c < 4000 && !is_done(); c++) begin
         ftdi_rx_rdy = 1'($urandom_range(0, 1));
         step();
      end
      ftdi_rx_rdy = 1'b1;
      wait_done("t4", 50);
      check("t4_rd0_count", nrd0 - b0, 100);
      check("t4_bytes", out_log.size() - bo, 100);
      if (out_log.size() - bo == 100)
         for (int i = 0; i < 100; i++) check("t4_byte", out_log[bo+i], (i * 3 + 7) % 256);

      // Test 5: s1 held off by its writer
      bo = out_log.size(); b1 = nrd1;
      s1_wrreq = 1'b1;
      for (int i = 0; i < 10; i++) f1.push_back(8'(8'h40 + i));
      repeat (30) step();
      check("t5_blocked", nrd1 - b1, 0);
      begin
         int n;
         bit got;
         s1_wrreq = 1'b0;
         n = 0; got = 1'b0;
         for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            n++;
            if (s1_rdreq) got = 1'b1;
         end
         check("t5_s1_latency", n, 3);
         @(posedge clk); #1;
      end
      wait_done("t5", 200);
      check("t5_bytes", out_log.size() - bo, 10);
      if (out_log.size() - bo == 10)
         for (int i = 0; i < 10; i++) check("t5_byte", out_log[bo+i], 8'h40 + i);

      // Test 6: reset while words are in flight and buffered
      b0 = nrd0;
      for (int i = 0; i < 20; i++) f0.push_back(8'(8'h10 + i));
      for (int c = 0; c < 200 && (nrd0 - b0) < 6; c++) step();
      check("t6_streaming", (nrd0 - b0) >= 6, 1);
      ftdi_rx_rdy = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      ftdi_rx_rdy = 1'b1;
      step();
      bo = out_log.size(); br = run_src.size();
      for (int i = 0; i < 3; i++) begin
         f0.push_back(8'(8'hA0 + i));
         f1.push_back(8'(8'hB0 + i));
      end
      wait_done("t6", 300);
      check("t6_runs", run_src.size() - br, 2);
      if (run_src.size() - br == 2) begin
         check("t6_first_src", run_src[br], 0);
         check("t6_second_src", run_src[br+1], 1);
      end
      check("t6_bytes", out_log.size() - bo, 6);
      if (out_log.size() - bo == 6) begin
         for (int i = 0; i < 3; i++) begin
            check("t6_s0_byte", out_log[bo+i], 8'hA0 + i);
            check("t6_s1_byte", out_log[bo+3+i], 8'hB0 + i);
         end
      end

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
